modn_sequencer: RTL and testbench
=================================

MODN_SEQUENCER -- requirements
Module: modn_sequencer

Interface
REQ-001 SHALL have parameter cnt_width, default 4, giving the counter and modulus width.
REQ-002 SHALL have parameter per_width, default 8, giving the period-count width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to launch a run; sampled only in IDLE.
REQ-006 SHALL have port stop  input  1  abort the current run.
REQ-007 SHALL have port pause  input  1  level; freezes counting while high.
REQ-008 SHALL have port mod_val  input  cnt_width  modulus N, captured on accepted start.
REQ-009 SHALL have port num_periods  input  per_width  wraps per run, captured on accepted start; 0 means free-run.
REQ-010 SHALL have port counter_out  output  cnt_width  current count, 0..N-1.
REQ-011 SHALL have port period_cnt  output  per_width  wraps completed in the current run.
REQ-012 SHALL have port busy  output  1  high in RUN and PAUSE.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse when counter_out returns to 0 from N-1.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the run completes normally.
REQ-015 SHALL have port err  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 SHALL implement the states IDLE, RUN, PAUSE and DONE; all outputs SHALL be registered.
REQ-017 IDLE with start=1, stop=0 and mod_val>=1 SHALL capture mod_val and num_periods and enter RUN next cycle with counter_out=0 and period_cnt=0.
REQ-018 IDLE with start=1 and mod_val=0 SHALL stay in IDLE and pulse err for one cycle.
REQ-019 In RUN with pause=0, counter_out SHALL increment once per clock; the count after N-1 SHALL be 0.
REQ-020 The N-1 to 0 transition SHALL pulse wrap in the cycle counter_out shows 0 and SHALL increment period_cnt in that same cycle.
REQ-021 With N=1, counter_out SHALL stay at 0 and wrap SHALL pulse on every counting cycle.
REQ-022 With num_periods!=0, the wrap that makes period_cnt equal num_periods SHALL send the state to DONE.
REQ-023 DONE SHALL pulse done for exactly one cycle, hold counter_out=0, and return to IDLE next cycle.
REQ-024 With num_periods=0, the block SHALL run until stop; period_cnt SHALL wrap modulo 2^per_width.
REQ-025 RUN with pause=1 SHALL enter PAUSE; PAUSE SHALL hold counter_out and period_cnt and SHALL NOT pulse wrap.
REQ-026 PAUSE SHALL return to RUN on the first cycle pause=0, and counting SHALL resume on that cycle.
REQ-027 stop=1 in RUN or PAUSE SHALL enter IDLE next cycle, clear counter_out and period_cnt, and SHALL NOT pulse done.
REQ-028 Event priority SHALL be stop > pause > count/wrap; a stop on the final-wrap cycle SHALL suppress both done and wrap.
REQ-029 start in RUN, PAUSE or DONE SHALL be ignored; a change to mod_val or num_periods after capture SHALL have no effect on the current run.
REQ-030 In IDLE, counter_out SHALL be 0, and period_cnt SHALL hold its last value until the next accepted start.

Reset
REQ-031 reset=1 SHALL, at the next clock edge, force IDLE and counter_out=0, period_cnt=0, busy=0, wrap=0, done=0 and err=0.
REQ-032 reset SHALL override all other inputs, including in the middle of a run.

Structure
REQ-033 A shared package SHALL hold the state enumeration (IDLE, RUN, PAUSE, DONE) and the default width constants.
REQ-034 The counting datapath SHALL be sub-module modn_count_core, with inputs clk, reset, clr, en and modulus, and outputs count and tc.
REQ-035 modn_sequencer SHALL contain only the FSM, the period counter and the capture registers.

Verification
REQ-036 Scenario: mod_val=13, num_periods=2, start pulsed -> counter_out runs 0..12,0..12; wrap pulses 13 and 26 cycles after RUN entry; done pulses once; then IDLE.
REQ-037 Scenario: mod_val=5, num_periods=1, pause held 3 cycles at count 2 -> count stays at 2 for 3 cycles; wrap occurs 3 cycles late; done pulses once.
REQ-038 Scenario: mod_val=13, num_periods=0, stop at count 7 -> IDLE next cycle; counter_out=0; no done pulse.
REQ-039 Scenario: mod_val=0, start -> err pulses once; busy stays 0. Then mod_val=1, num_periods=3 -> wrap pulses on 3 consecutive cycles, then done.
REQ-040 Scenario: reset asserted mid-run at count 9 -> next cycle all outputs 0 and state IDLE; start during RUN is ignored.

Source files
------------

// File: rtl/modn_sequencer_pkg.sv
// Shared types and default widths for the modulo-N run sequencer.
package modn_sequencer_pkg;

  localparam int CNT_WIDTH_DEF = 4;
  localparam int PER_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/modn_count_core.sv
// Modulo-N up-counter; tc flags the last count (N-1) so the caller can detect the wrap.
module modn_count_core
  import modn_sequencer_pkg::*;
#(
  parameter int cnt_width = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [cnt_width-1:0] modulus,
  output logic [cnt_width-1:0] count,
  output logic                 tc
);

  // With modulus 1 this is true at count 0, so the counter holds 0 and wraps every cycle.
  assign tc = (count == modulus - cnt_width'(1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + cnt_width'(1);
    end
  end

endmodule

// File: rtl/modn_sequencer.sv
// Run sequencer: launches a modulo-N count for a set number of wraps, with pause and abort.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | waiting for start; counter at 0, period_cnt held
// ST_RUN   | counting one step per clock
// ST_PAUSE | count and period_cnt frozen while pause is high
// ST_DONE  | one cycle after the final wrap; done pulses here
module modn_sequencer
  import modn_sequencer_pkg::*;
#(
  parameter int cnt_width = CNT_WIDTH_DEF,
  parameter int per_width = PER_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic [cnt_width-1:0] mod_val,
  input  logic [per_width-1:0] num_periods,
  output logic [cnt_width-1:0] counter_out,
  output logic [per_width-1:0] period_cnt,
  output logic                 busy,
  output logic                 wrap,
  output logic                 done,
  output logic                 err
);

  state_t               state;
  logic [cnt_width-1:0] mod_q;
  logic [per_width-1:0] num_q;
  logic [per_width-1:0] period_nxt;
  logic                 active;
  logic                 accept;
  logic                 reject;
  logic                 core_clr;
  logic                 core_en;
  logic                 tc;
  logic                 last_wrap;

  assign active     = (state == ST_RUN) || (state == ST_PAUSE);
  assign reject     = (state == ST_IDLE) && start && (mod_val == '0);
  assign accept     = (state == ST_IDLE) && start && !stop && (mod_val != '0);
  assign core_clr   = accept || (active && stop);
  // Leaving PAUSE and counting happen on the same edge, so only the live pause level gates.
  assign core_en    = active && !stop && !pause;
  assign period_nxt = period_cnt + per_width'(1);
  assign last_wrap  = (num_q != '0) && (period_nxt == num_q);

  modn_count_core #(
    .cnt_width(cnt_width)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (core_clr),
    .en     (core_en),
    .modulus(mod_q),
    .count  (counter_out),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mod_q      <= '0;
      num_q      <= '0;
      period_cnt <= '0;
      busy       <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (reject) begin
            err <= 1'b1;
          end else if (accept) begin
            mod_q      <= mod_val;
            num_q      <= num_periods;
            period_cnt <= '0;
            busy       <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (stop) begin
            period_cnt <= '0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (pause) begin
            state <= ST_PAUSE;
          end else begin
            state <= ST_RUN;
            if (tc) begin
              wrap       <= 1'b1;
              period_cnt <= period_nxt;
              if (last_wrap) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modn_sequencer.sv
// Directed bench for modn_sequencer with hand-computed expected values.
module tb_modn_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] mod_val;
  logic [7:0] num_periods;
  logic [3:0] counter_out;
  logic [7:0] period_cnt;
  logic       busy;
  logic       wrap;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  modn_sequencer #(.cnt_width(4), .per_width(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .mod_val    (mod_val),
    .num_periods(num_periods),
    .counter_out(counter_out),
    .period_cnt (period_cnt),
    .busy       (busy),
    .wrap       (wrap),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int cnt, input int pc, input bit b,
                         input bit w, input bit d, input bit e);
    chk({tag, ".cnt"}, 32'(counter_out), 32'(cnt));
    chk({tag, ".pc"}, 32'(period_cnt), 32'(pc));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".err"}, 32'(err), 32'(e));
  endtask

  task automatic launch(input logic [3:0] m, input logic [7:0] n);
    mod_val     = m;
    num_periods = n;
    start       = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mod_val = '0; num_periods = '0;
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    chk_all("idle", 0, 0, 0, 0, 0, 0);

    // N=13, two periods; mod_val change and start pulse mid-run must not matter
    launch(4'd13, 8'd2);
    chk_all("m13.entry", 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 26; k++) begin
      if (k == 5) begin mod_val = 4'd3; num_periods = 8'd1; end
      start = (k == 7);
      step();
      chk_all($sformatf("m13.k%0d", k), k % 13, (k >= 26) ? 2 : (k >= 13) ? 1 : 0,
              k < 26, (k == 13) || (k == 26), k == 26, 0);
    end
    start = 1'b0;
    step();
    chk_all("m13.idle", 0, 2, 0, 0, 0, 0);
    step();
    chk_all("m13.idle2", 0, 2, 0, 0, 0, 0);

    // N=5, one period, pause held for 3 edges at count 2
    launch(4'd5, 8'd1);
    chk_all("p5.entry", 0, 0, 1, 0, 0, 0);
    step(); step();
    chk_all("p5.c2", 2, 0, 1, 0, 0, 0);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("p5.hold%0d", k), 2, 0, 1, 0, 0, 0);
    end
    pause = 1'b0;
    step();
    chk_all("p5.resume", 3, 0, 1, 0, 0, 0);
    step();
    chk_all("p5.c4", 4, 0, 1, 0, 0, 0);
    step();
    chk_all("p5.wrap", 0, 1, 0, 1, 1, 0);
    step();
    chk_all("p5.idle", 0, 1, 0, 0, 0, 0);

    // N=13 free-run, stop at count 7
    launch(4'd13, 8'd0);
    for (int k = 0; k < 7; k++) step();
    chk_all("s13.c7", 7, 0, 1, 0, 0, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("s13.stop", 0, 0, 0, 0, 0, 0);
    step();
    chk_all("s13.idle", 0, 0, 0, 0, 0, 0);

    // mod_val=0 rejected, then N=1 for three periods
    mod_val = 4'd0; num_periods = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("rej.err", 0, 0, 0, 0, 0, 1);
    step();
    chk_all("rej.after", 0, 0, 0, 0, 0, 0);
    launch(4'd1, 8'd3);
    chk_all("n1.entry", 0, 0, 1, 0, 0, 0);
    step();
    chk_all("n1.w1", 0, 1, 1, 1, 0, 0);
    step();
    chk_all("n1.w2", 0, 2, 1, 1, 0, 0);
    step();
    chk_all("n1.w3", 0, 3, 0, 1, 1, 0);
    step();
    chk_all("n1.idle", 0, 3, 0, 0, 0, 0);

    // stop on the final-wrap cycle suppresses wrap and done
    launch(4'd2, 8'd1);
    step();
    chk_all("sf.c1", 1, 0, 1, 0, 0, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("sf.stop", 0, 0, 0, 0, 0, 0);

    // free-run period counter rolls over modulo 256
    launch(4'd1, 8'd0);
    for (int k = 0; k < 255; k++) step();
    chk_all("fr.255", 0, 255, 1, 1, 0, 0);
    step();
    chk_all("fr.256", 0, 0, 1, 1, 0, 0);
    step();
    chk_all("fr.257", 0, 1, 1, 1, 0, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("fr.stop", 0, 0, 0, 0, 0, 0);

    // start during RUN ignored; reset mid-run at count 9
    launch(4'd13, 8'd0);
    start = 1'b1; mod_val = 4'd4;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("rs.cnt%0d", k), 32'(counter_out), 32'(k));
    end
    start = 1'b0;
    chk_all("rs.c9", 9, 0, 1, 0, 0, 0);
    reset = 1'b1;
    step();
    chk_all("rs.reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    chk_all("rs.idle", 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
